// File: rtl/cvtfifo_pkg.sv
// Shared constants for the convertible packet FIFO controller: phase encoding,
// default address width and drop counter width.
package cvtfifo_pkg;

    localparam int AW_DEF = 8;
    localparam int DROP_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RX   = 3'd1,
        ST_PROC = 3'd2,
        ST_TX   = 3'd3,
        ST_DROP = 3'd4
    } state_e;

    // DROP is an internal refinement of RX and is reported as RX.
    function automatic logic [1:0] mode_of(state_e s);
        return (s == ST_DROP) ? 2'd1 : s[1:0];
    endfunction

endpackage

// File: rtl/cvtfifo_addr_gen.sv
// Wrapping buffer pointer with synchronous load (priority) and increment.
module cvtfifo_addr_gen
    import cvtfifo_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [AW-1:0] load_val_i,
    input  logic          inc_i,
    output logic [AW-1:0] addr_o
);

    logic [AW-1:0] addr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      addr_q <= '0;
        else if (load_i) addr_q <= load_val_i;
        else if (inc_i)  addr_q <= addr_q + 1'b1;
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/cvtfifo_ctrl.sv
// Phase sequencer for the packet buffer shared by the network port and the
// pipeline: receive, processor-owned, transmit, with overlong packets dropped.
module cvtfifo_ctrl
    import cvtfifo_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_eop,
    output logic              in_rdy,
    output logic              buf_we,
    output logic [AW-1:0]     wr_addr,
    output logic [AW-1:0]     rd_addr,
    output logic              out_valid,
    output logic              out_eop,
    input  logic              out_rdy,
    output logic              proc_go,
    output logic              proc_en,
    input  logic              proc_done,
    output logic [AW-1:0]     first_addr,
    output logic [AW-1:0]     last_addr,
    output logic [AW:0]       pkt_len,
    output logic [1:0]        mode,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [AW:0] MAXW = (AW+1)'(MAX_WORDS);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    state_e              state_q;
    logic [AW-1:0]       head_q, first_q, last_q;
    logic [AW:0]         cnt_q, len_q;
    logic                in_rdy_q, out_valid_q, proc_go_q, proc_en_q;
    logic [DROP_W-1:0]   drop_q;

    logic                xfer, tx_fire, tx_last, done_ok;
    logic                wr_load, rd_load;
    logic [AW-1:0]       wr_load_val;

    assign xfer    = in_valid & in_rdy_q;
    assign tx_fire = out_valid_q & out_rdy;
    assign tx_last = out_valid_q & (rd_addr == last_q);
    // A proc_done seen alongside the start pulse belongs to a previous run.
    assign done_ok = proc_done & ~proc_go_q;

    // Gated by reset so nothing is written while the controller is held.
    assign buf_we  = xfer & (state_q != ST_DROP) & reset;

    // Write pointer returns to head after a drop, or moves past the sent packet.
    assign wr_load     = ((state_q == ST_DROP) & in_valid & in_eop) |
                         ((state_q == ST_TX) & tx_fire & tx_last);
    assign wr_load_val = (state_q == ST_DROP) ? head_q : last_q + 1'b1;
    assign rd_load     = (state_q == ST_PROC) & done_ok;

    cvtfifo_addr_gen #(.AW(AW)) u_wr (
        .clk        (clk),
        .reset      (reset),
        .load_i     (wr_load),
        .load_val_i (wr_load_val),
        .inc_i      (buf_we),
        .addr_o     (wr_addr)
    );

    cvtfifo_addr_gen #(.AW(AW)) u_rd (
        .clk        (clk),
        .reset      (reset),
        .load_i     (rd_load),
        .load_val_i (first_q),
        .inc_i      (tx_fire),
        .addr_o     (rd_addr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            head_q      <= '0;
            first_q     <= '0;
            last_q      <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            in_rdy_q    <= 1'b1;
            out_valid_q <= 1'b0;
            proc_go_q   <= 1'b0;
            proc_en_q   <= 1'b0;
            drop_q      <= '0;
        end else begin
            proc_go_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (xfer) begin
                    first_q <= head_q;
                    cnt_q   <= ONE;
                    if (in_eop) begin
                        last_q    <= head_q;
                        len_q     <= ONE;
                        in_rdy_q  <= 1'b0;
                        proc_go_q <= 1'b1;
                        proc_en_q <= 1'b1;
                        state_q   <= ST_PROC;
                    end else if (MAXW == ONE) begin
                        state_q <= ST_DROP;
                    end else begin
                        state_q <= ST_RX;
                    end
                end
                ST_RX: if (xfer) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (in_eop) begin
                        last_q    <= wr_addr;
                        len_q     <= cnt_q + 1'b1;
                        in_rdy_q  <= 1'b0;
                        proc_go_q <= 1'b1;
                        proc_en_q <= 1'b1;
                        state_q   <= ST_PROC;
                    end else if (cnt_q + 1'b1 == MAXW) begin
                        state_q <= ST_DROP;
                    end
                end
                ST_DROP: if (in_valid && in_eop) begin
                    if (drop_q != '1) drop_q <= drop_q + 1'b1;
                    state_q <= ST_IDLE;
                end
                ST_PROC: if (done_ok) begin
                    proc_en_q   <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_TX;
                end
                ST_TX: if (tx_fire && tx_last) begin
                    head_q      <= last_q + 1'b1;
                    out_valid_q <= 1'b0;
                    in_rdy_q    <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_rdy     = in_rdy_q;
    assign out_valid  = out_valid_q;
    assign out_eop    = tx_last;
    assign proc_go    = proc_go_q;
    assign proc_en    = proc_en_q;
    assign first_addr = first_q;
    assign last_addr  = last_q;
    assign pkt_len    = len_q;
    assign mode       = mode_of(state_q);
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_cvtfifo_ctrl.sv
// Scoreboard bench for cvtfifo_ctrl: a packet-level model queues expected
// writes, processing descriptors and transmit words; a monitor consumes them.
module tb_cvtfifo_ctrl;

    localparam int AW = 8;
    localparam int MW = 8;

    logic clk = 1'b0;
    logic reset, in_valid, in_eop, out_rdy, proc_done;
    logic in_rdy, buf_we, out_valid, out_eop, proc_go, proc_en;
    logic [AW-1:0] wr_addr, rd_addr, first_addr, last_addr;
    logic [AW:0]   pkt_len;
    logic [1:0]    mode;
    logic [15:0]   drop_cnt;

    always #5 clk = ~clk;

    cvtfifo_ctrl #(.AW(AW), .MAX_WORDS(MW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_eop(in_eop),
        .in_rdy(in_rdy), .buf_we(buf_we), .wr_addr(wr_addr), .rd_addr(rd_addr),
        .out_valid(out_valid), .out_eop(out_eop), .out_rdy(out_rdy),
        .proc_go(proc_go), .proc_en(proc_en), .proc_done(proc_done),
        .first_addr(first_addr), .last_addr(last_addr), .pkt_len(pkt_len),
        .mode(mode), .drop_cnt(drop_cnt)
    );

    typedef struct packed {
        logic [7:0] first;
        logic [7:0] last;
        logic [8:0] len;
    } pexp_t;

    logic [7:0] wq[$];
    pexp_t      pq[$];
    logic [8:0] tq[$];

    int tests = 0, fails = 0;
    int head_m = 0, drop_m = 0;
    bit tog = 1'b0;
    int tp = 0;
    bit prev_go = 1'b0, prev_hold = 1'b0;
    logic [7:0] prev_rd = '0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail_now(string nm);
        tests++;
        fails++;
        $display("FAIL %s: DUT output with no expected entry", nm);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Downstream ready: random, or the 1,0,0 repeating pattern.
    always @(posedge clk) begin
        #1;
        if (tog) begin
            out_rdy <= (tp == 0);
            tp      <= (tp + 1) % 3;
        end else begin
            out_rdy <= ($urandom_range(0, 3) != 0);
            tp      <= 0;
        end
    end

    // Monitor: every DUT-presented event consumes one expected entry.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (buf_we) begin
                if (wq.size() == 0) fail_now("wr_extra");
                else chk("wr_addr", wr_addr, wq.pop_front());
            end
            if (proc_go) begin
                chk("go_pulse", prev_go, 0);
                if (pq.size() == 0) fail_now("go_extra");
                else begin
                    pexp_t p;
                    p = pq.pop_front();
                    chk("first_addr", first_addr, p.first);
                    chk("last_addr", last_addr, p.last);
                    chk("pkt_len", pkt_len, p.len);
                end
            end
            if (prev_hold) begin
                chk("valid_hold", out_valid, 1);
                chk("rd_hold", rd_addr, prev_rd);
            end
            if (out_valid && out_rdy) begin
                if (tq.size() == 0) fail_now("tx_extra");
                else chk("tx_word", {out_eop, rd_addr}, tq.pop_front());
            end
            prev_go   <= proc_go;
            prev_hold <= out_valid & ~out_rdy;
            prev_rd   <= rd_addr;
        end else begin
            prev_go   <= 1'b0;
            prev_hold <= 1'b0;
        end
    end

    task automatic check_reset_state(string t);
        chk({t, "_mode"}, mode, 0);
        chk({t, "_in_rdy"}, in_rdy, 1);
        chk({t, "_buf_we"}, buf_we, 0);
        chk({t, "_wr_addr"}, wr_addr, 0);
        chk({t, "_rd_addr"}, rd_addr, 0);
        chk({t, "_first"}, first_addr, 0);
        chk({t, "_last"}, last_addr, 0);
        chk({t, "_pkt_len"}, pkt_len, 0);
        chk({t, "_drop_cnt"}, drop_cnt, 0);
        chk({t, "_out_valid"}, out_valid, 0);
        chk({t, "_out_eop"}, out_eop, 0);
        chk({t, "_proc_go"}, proc_go, 0);
        chk({t, "_proc_en"}, proc_en, 0);
    endtask

    task automatic do_reset();
        #1 reset = 1'b0;
        #1;
        check_reset_state("rst");
        in_valid = 1'b0; in_eop = 1'b0; proc_done = 1'b0;
        wq.delete(); pq.delete(); tq.delete();
        head_m = 0; drop_m = 0;
        sync(); sync();
        reset = 1'b1;
        sync();
    endtask

    // Called at posedge+1; returns at posedge+1 just after the word is taken.
    task automatic send_word(bit eop);
        int n;
        in_valid = 1'b1;
        in_eop   = eop;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_rdy) break;
            n++;
            if (n > 100) begin
                chk("in_rdy_timeout", in_rdy, 1);
                break;
            end
        end
        sync();
    endtask

    task automatic send_partial(int len);
        for (int i = 0; i < len; i++) wq.push_back(8'((head_m + i) % 256));
        for (int i = 0; i < len; i++) send_word(1'b0);
    endtask

    task automatic send_pkt(int len, bit coinc, bit tg, bit abort_tx);
        int n;
        tog = tg;
        if (len > MW) begin
            for (int i = 0; i < MW; i++) wq.push_back(8'((head_m + i) % 256));
            if (drop_m < 65535) drop_m++;
        end else begin
            pexp_t p;
            for (int i = 0; i < len; i++) begin
                wq.push_back(8'((head_m + i) % 256));
                tq.push_back({1'(i == len - 1), 8'((head_m + i) % 256)});
            end
            p.first = 8'(head_m);
            p.last  = 8'((head_m + len - 1) % 256);
            p.len   = 9'(len);
            pq.push_back(p);
        end
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) sync();
            end
            send_word(i == len - 1);
        end
        in_valid = 1'b0;
        in_eop   = 1'b0;
        if (len > MW) begin
            @(negedge clk);
            chk("drop_mode", mode, 0);
            chk("drop_cnt", drop_cnt, drop_m);
            chk("drop_rdy", in_rdy, 1);
            sync();
        end else begin
            in_valid  = 1'b1;
            proc_done = coinc;
            @(negedge clk);
            chk("eop2go", proc_go, 1);
            chk("proc_rdy", in_rdy, 0);
            chk("proc_en", proc_en, 1);
            sync();
            in_valid  = 1'b0;
            proc_done = 1'b0;
            if (coinc) begin
                @(negedge clk);
                chk("early_done_mode", mode, 2);
                chk("early_done_ov", out_valid, 0);
                sync();
            end
            repeat ($urandom_range(0, 3)) sync();
            proc_done = 1'b1;
            sync();
            proc_done = 1'b0;
            in_valid  = 1'b1;
            @(negedge clk);
            chk("done2valid", out_valid, 1);
            chk("tx_mode", mode, 3);
            chk("tx_rdy", in_rdy, 0);
            chk("tx_en", proc_en, 0);
            #1 in_valid = 1'b0;
            if (abort_tx) begin
                sync(); sync();
                do_reset();
            end else begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (mode != 0 && n < 300);
                chk("tx_done", mode, 0);
                chk("tx2rdy", in_rdy, 1);
                sync();
                head_m = (head_m + len) % 256;
            end
        end
        tog = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        reset = 1'b0; in_valid = 1'b0; in_eop = 1'b0; proc_done = 1'b0;
        out_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("por");
        reset = 1'b1;
        sync();

        send_pkt(4, 1'b0, 1'b0, 1'b0);
        send_pkt(1, 1'b0, 1'b0, 1'b0);
        send_pkt(12, 1'b0, 1'b0, 1'b0);
        send_pkt(3, 1'b1, 1'b0, 1'b0);
        send_pkt(8, 1'b0, 1'b1, 1'b0);
        send_pkt(9, 1'b0, 1'b0, 1'b0);
        repeat (15) send_pkt($urandom_range(1, 12), 1'b0, 1'b0, 1'b0);

        // Walk head to 254 so the next packet straddles the wrap.
        while (head_m != 254) begin
            d = (254 - head_m + 256) % 256;
            send_pkt($urandom_range(1, (d < MW) ? d : MW), 1'b0, 1'b0, 1'b0);
        end
        send_pkt(5, 1'b0, 1'b1, 1'b0);
        send_pkt(2, 1'b0, 1'b0, 1'b0);

        send_partial(3);
        do_reset();
        send_pkt(4, 1'b0, 1'b0, 1'b0);
        send_pkt(6, 1'b0, 1'b1, 1'b1);
        send_pkt(3, 1'b0, 1'b0, 1'b0);

        repeat (2) sync();
        chk("wq_empty", wq.size(), 0);
        chk("pq_empty", pq.size(), 0);
        chk("tq_empty", tq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
